// File: rtl/rx_ctrl_if.sv
// rtl/rx_ctrl_if.sv - receiver handshake and host valid/ready bundle for rx_ctrl
interface rx_ctrl_if #(
    parameter int DEPTH         = 8,
    parameter int ERR_CNT_WIDTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                     Receive;
    logic [7:0]               Din;
    logic                     parityErr;
    logic                     ReceiveAck;
    logic [7:0]               Dout;
    logic                     DoutErr;
    logic                     Valid;
    logic                     Ready;
    logic                     ClrStatus;
    logic                     Overflow;
    logic [ERR_CNT_WIDTH-1:0] ErrCount;
    logic [LW-1:0]            Level;

    modport slave (
        input  Receive, Din, parityErr, Ready, ClrStatus,
        output ReceiveAck, Dout, DoutErr, Valid, Overflow, ErrCount, Level
    );

    modport master (
        output Receive, Din, parityErr, Ready, ClrStatus,
        input  ReceiveAck, Dout, DoutErr, Valid, Overflow, ErrCount, Level
    );
endinterface

// File: rtl/rx_ctrl.sv
// rtl/rx_ctrl.sv - UART receive handshake, show-ahead byte FIFO and status; RX_PARITY_DROP_EN drops errored bytes
module rx_ctrl #(
    parameter int DEPTH         = 8,
    parameter int ERR_CNT_WIDTH = 8
) (
    input logic     clk,
    input logic     rst,
    rx_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, ACK} state_t;

    state_t                   state;
    logic                     ack;
    logic [8:0]               mem [DEPTH];
    logic [AW-1:0]            rd_ptr;
    logic [AW-1:0]            wr_ptr;
    logic [LW-1:0]            level;
    logic                     overflow;
    logic [ERR_CNT_WIDTH-1:0] err_count;

    logic capture;
    logic full;
    logic pop;
    logic push;
    logic drop_parity;

    assign capture = (state == IDLE) && bus.Receive;
    assign full    = (level == LW'(DEPTH));
    assign pop     = (level != '0) && bus.Ready;
`ifdef RX_PARITY_DROP_EN
    assign drop_parity = bus.parityErr;
`else
    assign drop_parity = 1'b0;
`endif
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign push = capture && !drop_parity && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ack   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.Receive) begin
                    state <= ACK;
                    ack   <= 1'b1;
                end
                ACK: if (!bus.Receive) begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {bus.parityErr, bus.Din};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
        end
    end

    // Clear wins over a same-cycle set or increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else if (bus.ClrStatus) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (capture && !drop_parity && full && !pop) overflow <= 1'b1;
            if (capture && bus.parityErr && (err_count != '1)) err_count <= err_count + 1'b1;
        end
    end

    assign bus.ReceiveAck = ack;
    assign bus.Dout       = mem[rd_ptr][7:0];
`ifdef RX_PARITY_DROP_EN
    assign bus.DoutErr    = 1'b0;
`else
    assign bus.DoutErr    = mem[rd_ptr][8];
`endif
    assign bus.Valid      = (level != '0);
    assign bus.Level      = level;
    assign bus.Overflow   = overflow;
    assign bus.ErrCount   = err_count;
endmodule

// File: tb/tb_rx_ctrl.sv
// tb/tb_rx_ctrl.sv - randomized self-checking bench for rx_ctrl against a queue-based model
module tb_rx_ctrl;
    localparam int DEPTH  = 8;
    localparam int ECW    = 8;
    localparam int ERRMAX = (1 << ECW) - 1;
`ifdef RX_PARITY_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic clk;
    logic rst;

    rx_ctrl_if #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(ECW)) bif ();

    rx_ctrl #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(ECW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [8:0] q[$];
    bit         m_ovf;
    int         m_err;
    int         rdy_mode;
    bit         clr_rand;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic next_ready();
        if (rdy_mode == 0) return 1'b0;
        if (rdy_mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    // Effect of one clock edge, from the byte-level rules
    task automatic model_edge(input bit cap, input logic [7:0] b, input bit pe, input bit rdy, input bit clr);
        int  n;
        bit  pop;
        n   = q.size();
        pop = rdy && (n > 0);
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (!(DROP && pe)) begin
                if (n < DEPTH || pop) q.push_back({pe, b});
                else m_ovf = 1'b1;
            end
            if (pe && m_err < ERRMAX) m_err++;
        end
        if (clr) begin
            m_ovf = 1'b0;
            m_err = 0;
        end
    endtask

    task automatic check_outputs(input bit exp_ack);
        check("ack", bif.ReceiveAck, exp_ack);
        check("valid", bif.Valid, q.size() > 0);
        check("level", bif.Level, q.size());
        check("overflow", bif.Overflow, m_ovf);
        check("errcount", bif.ErrCount, m_err);
        if (q.size() > 0) begin
            check("dout", bif.Dout, q[0][7:0]);
            check("douterr", bif.DoutErr, q[0][8]);
        end
    endtask

    // Called at a falling edge: drive, step the model, advance one cycle, check
    task automatic do_cycle(input bit rcv, input bit cap, input logic [7:0] b, input bit pe, input bit clr, input bit exp_ack);
        bit c;
        c = clr || (clr_rand && ($urandom_range(0, 29) == 0));
        bif.Receive   = rcv;
        bif.Din       = b;
        bif.parityErr = pe;
        bif.Ready     = next_ready();
        bif.ClrStatus = c;
        model_edge(cap, b, pe, bif.Ready, c);
        @(posedge clk);
        @(negedge clk);
        check_outputs(exp_ack);
    endtask

    task automatic send(input logic [7:0] b, input bit pe);
        do_cycle(1'b1, 1'b1, b, pe, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, b, pe, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        do_cycle(1'b0, 1'b0, 8'($urandom), 1'b0, clr, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bif.Receive = 0; bif.Din = 0; bif.parityErr = 0; bif.Ready = 0; bif.ClrStatus = 0;
        m_ovf = 0; m_err = 0; rdy_mode = 0; clr_rand = 0;
        repeat (2) @(negedge clk);
        check("rst_ack", bif.ReceiveAck, 0);
        check("rst_valid", bif.Valid, 0);
        check("rst_level", bif.Level, 0);
        check("rst_ovf", bif.Overflow, 0);
        check("rst_err", bif.ErrCount, 0);
        check("rst_dout", bif.Dout, 0);
        check("rst_douterr", bif.DoutErr, 0);
        rst = 1'b0;

        send(8'hA5, 1'b0);
        rdy_mode = 1;
        idle(1'b0);
        rdy_mode = 0;

        for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
        check("ten_ovf", bif.Overflow, 1);
        rdy_mode = 1;
        repeat (8) idle(1'b0);
        rdy_mode = 0;
        idle(1'b1);

        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b0);
        rdy_mode = 1;
        do_cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
        rdy_mode = 0;
        do_cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("full_pop_level", bif.Level, 8);
        rdy_mode = 1;
        repeat (8) idle(1'b0);

        send(8'h5A, 1'b1);
        idle(1'b0);

        for (int i = 0; i < 300; i++) send(8'($urandom), 1'b1);
        check("err_sat", bif.ErrCount, ERRMAX);
        idle(1'b1);

        rdy_mode = 2;
        clr_rand = 1;
        for (int i = 0; i < 150; i++) begin
            send(8'($urandom), ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) idle(1'b0);
        end
        clr_rand = 0;
        rdy_mode = 1;
        repeat (DEPTH + 1) idle(1'b0);

        rdy_mode = 0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        do_cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        check("pre_rst_level", bif.Level, 3);
        rst = 1'b1;
        bif.Receive = 1'b0;
        #1;
        check("async_ack", bif.ReceiveAck, 0);
        check("async_valid", bif.Valid, 0);
        check("async_level", bif.Level, 0);
        q.delete();
        m_ovf = 0;
        m_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send(8'h77, 1'b0);
        rdy_mode = 1;
        idle(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_ctrl.md
# rx_ctrl

Receive-side controller between the UART receiver and the host logic. Performs the receiver's Receive/ReceiveAck handshake, buffers received bytes and their parity flags in a show-ahead FIFO, and presents them on a valid/ready interface. Also keeps overflow and parity-error status, so the receiver never stalls waiting for a slow consumer.

## Interface
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- ERR_CNT_WIDTH, 8: width of the parity-error counter.
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; asynchronous, active-high. Clears all state.
- Receive  in  1  receiver has a byte on Din; held until acknowledged.
- Din  in  8  received byte; valid while Receive is high.
- parityErr  in  1  parity error for Din; valid while Receive is high.
- ReceiveAck  out  1  acknowledge to the receiver; registered.
- Dout  out  8  FIFO head byte; valid while Valid is high.
- DoutErr  out  1  parity flag stored with the head byte.
- Valid  out  1  FIFO is non-empty.
- Ready  in  1  host pops the head when Valid && Ready.
- ClrStatus  in  1  synchronous clear of Overflow and ErrCount.
- Overflow  out  1  sticky; a byte arrived while the FIFO was full.
- ErrCount  out  ERR_CNT_WIDTH  saturating count of bytes received with parityErr = 1.
- Level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states:
  - IDLE: if Receive, capture the byte and go to ACK.
  - ACK: ReceiveAck = 1. Stay in ACK while Receive = 1. When Receive = 0, go to IDLE.
- Capture happens exactly once per Receive assertion, on the IDLE-to-ACK edge.
  - Push {parityErr, Din} if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise drop the byte and set Overflow.
- ErrCount increments on every capture where parityErr = 1, including dropped bytes. It saturates at all-ones.
- FIFO:
  - Circular buffer with $clog2(DEPTH)-bit read and write pointers that wrap naturally.
  - Level is (DEPTH)-capable.
  - Show-ahead: Dout and DoutErr equal the head entry combinationally from the registered array.
- Pop when Valid && Ready. A pop while empty is ignored.
- Push and pop in the same cycle leave Level unchanged. This holds at every occupancy, including full and empty.
- ClrStatus clears Overflow and ErrCount at the next edge. If a set or increment occurs in the same cycle, the clear wins.

## Timing
- Reset values:
  - state = IDLE, ReceiveAck = 0, Valid = 0, Level = 0.
  - Overflow = 0, ErrCount = 0, Dout = 0, DoutErr = 0.
- Receive is sampled high at edge N:
  - The byte is written at edge N.
  - Valid is high in cycle N+1 (if the FIFO was empty).
  - ReceiveAck is high from cycle N+1.
- The receiver drops Receive one edge after it sees ReceiveAck. ReceiveAck then falls the edge after Receive is sampled low, giving a 2-cycle acknowledge for a compliant receiver.
- Minimum spacing between captures is 3 cycles. UART byte time is about 5200 cycles, so throughput is limited only by the consumer.
- Pop latency: the next head is visible in the cycle after the popping edge.
- Reset asserted mid-handshake: the FSM returns to IDLE and ReceiveAck drops immediately (asynchronously). The FIFO contents are discarded.

## Configuration
- RX_PARITY_DROP_EN defined:
  - Bytes with parityErr = 1 are counted in ErrCount but not pushed.
  - The handshake still completes.
  - DoutErr is tied to 0.
- RX_PARITY_DROP_EN undefined: errored bytes are pushed, with DoutErr = 1 stored alongside.

## Test plan
- Single byte 0xA5 with parityErr = 0 and Ready = 0:
  - ReceiveAck pulses for 2 cycles.
  - Valid = 1, Dout = 0xA5, DoutErr = 0, Level = 1.
  - Ready = 1 for one cycle, then Valid = 0.
- DEPTH = 8, Ready = 0, ten bytes 0x00..0x09:
  - Level = 8 and Overflow = 1.
  - The host drains 0x00..0x07 in order; 0x08 and 0x09 are lost.
  - ClrStatus then gives Overflow = 0.
- FIFO full and Ready = 1 in the same cycle as capture of 0x3C: Overflow stays 0, Level stays 8, 0x3C is the last entry drained.
- Byte 0x5A with parityErr = 1:
  - ErrCount = 1.
  - Without RX_PARITY_DROP_EN: Dout = 0x5A, DoutErr = 1.
  - With RX_PARITY_DROP_EN: Valid stays 0.
- 300 parity-error bytes with ERR_CNT_WIDTH = 8: ErrCount saturates at 255 and does not wrap.
- rst asserted while in ACK with Level = 3: ReceiveAck, Valid and Level are 0 immediately, without waiting for a clk edge. After rst is released, the next byte is captured normally.
